// File: rtl/cell_render_pipe_pkg.sv
// Shared definitions for the life-board cell renderer: modes, colours,
// the zoom-to-shift encoding and the flag bundle carried down the pipeline.
package cell_render_pipe_pkg;

    typedef enum logic {
        MODE_EDIT = 1'b0,
        MODE_RUN  = 1'b1
    } mode_e;

    localparam logic [11:0] COL_BG       = 12'h000;
    localparam logic [11:0] COL_GRID     = 12'h333;
    localparam logic [11:0] COL_CUR_GRID = 12'h700;
    localparam logic [11:0] COL_CUR      = 12'h0F0;
    localparam logic [11:0] COL_ALIVE    = 12'hFF0;
    localparam logic [11:0] COL_DEAD     = 12'hFFF;

    localparam logic [2:0] SHIFT_RESET = 3'd6;

    typedef struct packed {
        logic valid;
        logic area;
        logic grid;
        logic hit;
        logic cur_en;
    } flags_t;

    // Highest set bit of visi_cell_num[5:3] selects the cell width (8..64 px).
    function automatic logic [2:0] zoom_to_shift(input logic [7:0] visi);
        logic [2:0] sh;
        if (visi[5]) begin
            sh = 3'd3;
        end else if (visi[4]) begin
            sh = 3'd4;
        end else if (visi[3]) begin
            sh = 3'd5;
        end else begin
            sh = 3'd6;
        end
        return sh;
    endfunction

endpackage

// File: rtl/cell_render_pipe_if.sv
// Cell-state memory read port: the renderer drives the address, memory
// returns the alive flag a fixed number of cycles later.
interface cell_render_pipe_if #(
    parameter int K = 6
);
    logic [K-1:0] cell_x;
    logic [K-1:0] cell_y;
    logic         cell_state;

    modport master (output cell_x, output cell_y, input cell_state);
    modport slave  (input cell_x, input cell_y, output cell_state);
endinterface

// File: rtl/cell_render_pipe_shift_map.sv
// Power-of-two cell mapping: quotient and remainder of a window-relative
// pixel offset by the current cell width, using shifts only.
module cell_shift_map #(
    parameter int K = 6
) (
    input  logic [9:0]   rel,
    input  logic [2:0]   shift,
    output logic [K-1:0] quo,
    output logic [9:0]   rem
);
    logic [9:0] mask_s;

    // Quotient keeps only K bits so oversized offsets wrap around the board.
    always_comb begin
        mask_s = (10'd1 << shift) - 10'd1;
        quo    = K'(rel >> shift);
        rem    = rel & mask_s;
    end
endmodule

// File: rtl/cell_render_pipe.sv
// Pixel-to-cell renderer: maps scan pixels onto a toroidal board window,
// issues the cell read and colours the aligned cell state. Latency 3+MEM_LAT.
module cell_render_pipe
    import cell_render_pipe_pkg::*;
#(
    parameter int K            = 6,
    parameter int PX_BOUND_LM  = 50,
    parameter int PX_BOUND_RM  = 400,
    parameter int PX_BOUND_UM  = 50,
    parameter int PX_BOUND_DM  = 400,
    parameter int MEM_LAT      = 1,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      pix_valid,
    input  logic                      mode,
    input  logic [9:0]                scan_x,
    input  logic [9:0]                scan_y,
    input  logic [K-1:0]              win_x,
    input  logic [K-1:0]              win_y,
    input  logic [7:0]                visi_cell_num,
    input  logic [K-1:0]              cur_x,
    input  logic [K-1:0]              cur_y,
    cell_render_pipe_if.master        mem,
    output logic                      disp_valid,
    output logic                      in_disp_area,
    output logic [11:0]               disp_value_RGB
);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [2:0]    shift_q_r;
    logic [BW-1:0] blink_cnt_r;
    logic          blink_on_r;

    logic [9:0]    rel_x_r, rel_y_r;
    logic          area_r, valid_r, mode_r;

    logic [K-1:0]  qx_s, qy_s, cx_s, cy_s;
    logic [9:0]    rx_s, ry_s;
    logic [K-1:0]  cell_x_r, cell_y_r;
    flags_t        s1_flags_s, s1_flags_r, out_flags_s;

    logic [11:0]   rgb_s;
    logic          disp_valid_r, in_disp_area_r;
    logic [11:0]   rgb_r;

    // Zoom is sampled only at frame start so a frame never changes cell size.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q_r <= SHIFT_RESET;
        end else if (frame_start) begin
            shift_q_r <= zoom_to_shift(visi_cell_num);
        end
    end

    // Cursor blink timer; RUN mode pins it to the visible phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
        end else if (mode == MODE_RUN) begin
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt_r == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_r <= '0;
                blink_on_r  <= ~blink_on_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BW'(1);
            end
        end
    end

    // S0: bounds test and display-relative offsets.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rel_x_r <= 10'd0;
            rel_y_r <= 10'd0;
            area_r  <= 1'b0;
            valid_r <= 1'b0;
            mode_r  <= 1'b0;
        end else begin
            rel_x_r <= scan_x - 10'(PX_BOUND_LM + 1);
            rel_y_r <= scan_y - 10'(PX_BOUND_UM + 1);
            area_r  <= (scan_x > 10'(PX_BOUND_LM)) && (scan_x < 10'(PX_BOUND_RM)) &&
                       (scan_y > 10'(PX_BOUND_UM)) && (scan_y < 10'(PX_BOUND_DM));
            valid_r <= pix_valid;
            mode_r  <= mode;
        end
    end

    cell_shift_map #(.K(K)) u_map_x (.rel(rel_x_r), .shift(shift_q_r), .quo(qx_s), .rem(rx_s));
    cell_shift_map #(.K(K)) u_map_y (.rel(rel_y_r), .shift(shift_q_r), .quo(qy_s), .rem(ry_s));

    // S1 combinational: window origin added modulo 2^K, grid and cursor flags.
    always_comb begin
        cx_s              = win_x + qx_s;
        cy_s              = win_y + qy_s;
        s1_flags_s.valid  = valid_r;
        s1_flags_s.area   = area_r;
        s1_flags_s.grid   = (rx_s == 10'd0) || (ry_s == 10'd0);
        s1_flags_s.hit    = (cx_s == cur_x) && (cy_s == cur_y);
        s1_flags_s.cur_en = s1_flags_s.hit && (mode_r == MODE_EDIT);
    end

    // S1 registers: memory address and the flags that travel alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cell_x_r   <= '0;
            cell_y_r   <= '0;
            s1_flags_r <= '0;
        end else begin
            cell_x_r   <= cx_s;
            cell_y_r   <= cy_s;
            s1_flags_r <= s1_flags_s;
        end
    end

    assign mem.cell_x = cell_x_r;
    assign mem.cell_y = cell_y_r;

    generate
        if (MEM_LAT == 0) begin : g_no_dly
            assign out_flags_s = s1_flags_r;
        end else begin : g_dly
            flags_t dly_r [MEM_LAT];

            // Flag delay matching the memory read latency.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < MEM_LAT; i++) begin
                        dly_r[i] <= '0;
                    end
                end else begin
                    dly_r[0] <= s1_flags_r;
                    for (int i = 1; i < MEM_LAT; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end
            end

            assign out_flags_s = dly_r[MEM_LAT-1];
        end
    endgenerate

    // Colour priority; invalid pixels are always black.
    always_comb begin
        rgb_s = COL_BG;
        if (!out_flags_s.valid || !out_flags_s.area) begin
            rgb_s = COL_BG;
        end else if (out_flags_s.grid && out_flags_s.cur_en) begin
            rgb_s = COL_CUR_GRID;
        end else if (out_flags_s.grid) begin
            rgb_s = COL_GRID;
        end else if (out_flags_s.cur_en && blink_on_r) begin
            rgb_s = COL_CUR;
        end else if (out_flags_s.hit && (mode_r == MODE_RUN)) begin
            rgb_s = COL_CUR;
        end else if (mem.cell_state) begin
            rgb_s = COL_ALIVE;
        end else begin
            rgb_s = COL_DEAD;
        end
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_valid_r   <= 1'b0;
            in_disp_area_r <= 1'b0;
            rgb_r          <= 12'h000;
        end else begin
            disp_valid_r   <= out_flags_s.valid;
            in_disp_area_r <= out_flags_s.area;
            rgb_r          <= rgb_s;
        end
    end

    assign disp_valid     = disp_valid_r;
    assign in_disp_area   = in_disp_area_r;
    assign disp_value_RGB = rgb_r;

endmodule

// File: tb/tb_cell_render_pipe.sv
// Directed bench for cell_render_pipe: four instances (MEM_LAT 0..3) share
// the stimulus; instance 1 (BLINK_FRAMES=2) carries most of the checks.
module tb_cell_render_pipe;
    import cell_render_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start, pix_valid, mode;
    logic [9:0]  scan_x, scan_y;
    logic [5:0]  win_x, win_y, cur_x, cur_y;
    logic [7:0]  visi_cell_num;
    logic        dv   [4];
    logic        area [4];
    logic [11:0] rgb  [4];

    int checks = 0;
    int errors = 0;

    int          lat   [4];
    logic [11:0] rgbc  [4];
    logic        areac [4];
    logic [5:0]  cx2, cy2;

    always #5 clk = ~clk;

    cell_render_pipe_if #(.K(6)) mem0 ();
    cell_render_pipe_if #(.K(6)) mem1 ();
    cell_render_pipe_if #(.K(6)) mem2 ();
    cell_render_pipe_if #(.K(6)) mem3 ();

    cell_render_pipe #(.K(6), .MEM_LAT(0)) u_l0 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .mode(mode),
        .scan_x(scan_x), .scan_y(scan_y), .win_x(win_x), .win_y(win_y),
        .visi_cell_num(visi_cell_num), .cur_x(cur_x), .cur_y(cur_y), .mem(mem0),
        .disp_valid(dv[0]), .in_disp_area(area[0]), .disp_value_RGB(rgb[0]));
    cell_render_pipe #(.K(6), .MEM_LAT(1), .BLINK_FRAMES(2)) u_l1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .mode(mode),
        .scan_x(scan_x), .scan_y(scan_y), .win_x(win_x), .win_y(win_y),
        .visi_cell_num(visi_cell_num), .cur_x(cur_x), .cur_y(cur_y), .mem(mem1),
        .disp_valid(dv[1]), .in_disp_area(area[1]), .disp_value_RGB(rgb[1]));
    cell_render_pipe #(.K(6), .MEM_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .mode(mode),
        .scan_x(scan_x), .scan_y(scan_y), .win_x(win_x), .win_y(win_y),
        .visi_cell_num(visi_cell_num), .cur_x(cur_x), .cur_y(cur_y), .mem(mem2),
        .disp_valid(dv[2]), .in_disp_area(area[2]), .disp_value_RGB(rgb[2]));
    cell_render_pipe #(.K(6), .MEM_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .mode(mode),
        .scan_x(scan_x), .scan_y(scan_y), .win_x(win_x), .win_y(win_y),
        .visi_cell_num(visi_cell_num), .cur_x(cur_x), .cur_y(cur_y), .mem(mem3),
        .disp_valid(dv[3]), .in_disp_area(area[3]), .disp_value_RGB(rgb[3]));

    // Board model: every odd column is alive.
    function automatic logic alive(input logic [5:0] x);
        return x[0];
    endfunction

    logic       p1;
    logic [1:0] p2;
    logic [2:0] p3;
    assign mem0.cell_state = alive(mem0.cell_x);
    always @(posedge clk) begin
        p1 <= alive(mem1.cell_x);
        p2 <= {p2[0], alive(mem2.cell_x)};
        p3 <= {p3[1:0], alive(mem3.cell_x)};
    end
    assign mem1.cell_state = p1;
    assign mem2.cell_state = p2[1];
    assign mem3.cell_state = p3[2];

    typedef struct {
        logic [9:0]  sx, sy;
        logic        pv, md;
        logic [5:0]  wx, wy, ux, uy;
        logic        ev, ea;
        logic [11:0] ergb;
        logic        ck;
        logic [5:0]  ecx, ecy;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] sx, input logic [9:0] sy, input logic pv);
        scan_x    = sx;
        scan_y    = sy;
        pix_valid = pv;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    // One valid pixel between invalid background pixels; record first disp_valid per instance.
    task automatic pulse_pixel(input logic [9:0] sx, input logic [9:0] sy,
                               input logic [9:0] bx, input logic [9:0] by);
        for (int d = 0; d < 4; d++) begin
            lat[d]   = 0;
            rgbc[d]  = 12'h000;
            areac[d] = 1'b0;
        end
        drive(bx, by, 1'b0);
        tick(8);
        drive(sx, sy, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) drive(bx, by, 1'b0);
            if (k == 2) begin
                cx2 = mem1.cell_x;
                cy2 = mem1.cell_y;
            end
            for (int d = 0; d < 4; d++) begin
                if (dv[d] && lat[d] == 0) begin
                    lat[d]   = k;
                    rgbc[d]  = rgb[d];
                    areac[d] = area[d];
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // sx sy pv md wx wy ux uy | ev ea rgb ck cx cy   (zoom 8 px)
        vt[0]  = '{10'd51,  10'd51,  1'b1, 1'b1, 6'd0,  6'd0,  6'd10, 6'd10, 1'b1, 1'b1, 12'h333, 1'b1, 6'd0,  6'd0};
        vt[1]  = '{10'd60,  10'd54,  1'b1, 1'b1, 6'd0,  6'd0,  6'd10, 6'd10, 1'b1, 1'b1, 12'hFF0, 1'b1, 6'd1,  6'd0};
        vt[2]  = '{10'd68,  10'd54,  1'b1, 1'b1, 6'd0,  6'd0,  6'd10, 6'd10, 1'b1, 1'b1, 12'hFFF, 1'b1, 6'd2,  6'd0};
        vt[3]  = '{10'd77,  10'd54,  1'b1, 1'b1, 6'd62, 6'd0,  6'd10, 6'd10, 1'b1, 1'b1, 12'hFF0, 1'b1, 6'd1,  6'd0};
        vt[4]  = '{10'd20,  10'd200, 1'b1, 1'b1, 6'd0,  6'd0,  6'd10, 6'd10, 1'b1, 1'b0, 12'h000, 1'b0, 6'd0,  6'd0};
        vt[5]  = '{10'd60,  10'd54,  1'b0, 1'b1, 6'd0,  6'd0,  6'd10, 6'd10, 1'b0, 1'b1, 12'h000, 1'b1, 6'd1,  6'd0};
        vt[6]  = '{10'd50,  10'd54,  1'b1, 1'b1, 6'd0,  6'd0,  6'd10, 6'd10, 1'b1, 1'b0, 12'h000, 1'b0, 6'd0,  6'd0};
        vt[7]  = '{10'd399, 10'd54,  1'b1, 1'b1, 6'd0,  6'd0,  6'd10, 6'd10, 1'b1, 1'b1, 12'hFF0, 1'b1, 6'd43, 6'd0};
        vt[8]  = '{10'd400, 10'd54,  1'b1, 1'b1, 6'd0,  6'd0,  6'd10, 6'd10, 1'b1, 1'b0, 12'h000, 1'b0, 6'd0,  6'd0};
        vt[9]  = '{10'd60,  10'd400, 1'b1, 1'b1, 6'd0,  6'd0,  6'd10, 6'd10, 1'b1, 1'b0, 12'h000, 1'b0, 6'd0,  6'd0};
        vt[10] = '{10'd60,  10'd54,  1'b1, 1'b1, 6'd0,  6'd0,  6'd1,  6'd0,  1'b1, 1'b1, 12'h0F0, 1'b1, 6'd1,  6'd0};
        vt[11] = '{10'd68,  10'd54,  1'b1, 1'b0, 6'd0,  6'd0,  6'd2,  6'd0,  1'b1, 1'b1, 12'h0F0, 1'b1, 6'd2,  6'd0};
        vt[12] = '{10'd67,  10'd54,  1'b1, 1'b0, 6'd0,  6'd0,  6'd2,  6'd0,  1'b1, 1'b1, 12'h700, 1'b1, 6'd2,  6'd0};
        vt[13] = '{10'd67,  10'd54,  1'b1, 1'b1, 6'd0,  6'd0,  6'd2,  6'd0,  1'b1, 1'b1, 12'h333, 1'b1, 6'd2,  6'd0};
        vt[14] = '{10'd60,  10'd60,  1'b1, 1'b1, 6'd0,  6'd63, 6'd10, 6'd10, 1'b1, 1'b1, 12'hFF0, 1'b1, 6'd1,  6'd0};
        vt[15] = '{10'd60,  10'd50,  1'b1, 1'b1, 6'd0,  6'd0,  6'd10, 6'd10, 1'b1, 1'b0, 12'h000, 1'b0, 6'd0,  6'd0};

        rst = 1'b0; frame_start = 1'b0; mode = 1'b1; visi_cell_num = 8'h00;
        win_x = 6'd0; win_y = 6'd0; cur_x = 6'd10; cur_y = 6'd10;
        drive(10'd60, 10'd54, 1'b1);
        tick(3);
        chk("reset disp_valid", 32'(dv[1]), 32'd0);
        chk("reset in_disp_area", 32'(area[1]), 32'd0);
        chk("reset rgb", 32'(rgb[1]), 32'h000);
        chk("reset cell_x", 32'(mem1.cell_x), 32'd0);
        chk("reset cell_y", 32'(mem1.cell_y), 32'd0);

        // Reset zoom is 64 px: rel_x=65 lands in column 1.
        rst = 1'b1;
        drive(10'd116, 10'd54, 1'b1);
        tick(6);
        chk("reset zoom cell_x", 32'(mem1.cell_x), 32'd1);

        visi_cell_num = 8'h20;
        pulse_fs();
        pulse_pixel(10'd51, 10'd51, 10'd68, 10'd54);
        chk("first latency", 32'(lat[1]), 32'd4);
        chk("first rgb", 32'(rgbc[1]), 32'h333);
        chk("first area", 32'(areac[1]), 32'd1);
        chk("first cell_x", 32'(cx2), 32'd0);
        chk("first cell_y", 32'(cy2), 32'd0);

        for (int i = 0; i < 16; i++) begin
            mode = vt[i].md; win_x = vt[i].wx; win_y = vt[i].wy;
            cur_x = vt[i].ux; cur_y = vt[i].uy;
            drive(vt[i].sx, vt[i].sy, vt[i].pv);
            tick(6);
            chk($sformatf("vec%0d disp_valid", i), 32'(dv[1]), 32'(vt[i].ev));
            chk($sformatf("vec%0d in_disp_area", i), 32'(area[1]), 32'(vt[i].ea));
            chk($sformatf("vec%0d rgb", i), 32'(rgb[1]), 32'(vt[i].ergb));
            if (vt[i].ck) begin
                chk($sformatf("vec%0d cell_x", i), 32'(mem1.cell_x), 32'(vt[i].ecx));
                chk($sformatf("vec%0d cell_y", i), 32'(mem1.cell_y), 32'(vt[i].ecy));
            end
        end

        // Zoom latch: new visi_cell_num only takes effect at frame_start.
        mode = 1'b1; win_x = 6'd0; win_y = 6'd0; cur_x = 6'd10; cur_y = 6'd10;
        visi_cell_num = 8'h08;
        drive(10'd91, 10'd54, 1'b1);
        tick(6);
        chk("zoom before fs cell_x", 32'(mem1.cell_x), 32'd5);
        pulse_fs();
        tick(6);
        chk("zoom after fs cell_x", 32'(mem1.cell_x), 32'd1);
        visi_cell_num = 8'h20;
        pulse_fs();

        // Cursor blink with BLINK_FRAMES=2 on a dead cursor cell.
        mode = 1'b0; cur_x = 6'd2; cur_y = 6'd0;
        for (int f = 0; f < 6; f++) begin
            if (f > 0) pulse_fs();
            drive(10'd68, 10'd54, 1'b1);
            tick(6);
            chk($sformatf("blink f%0d body", f), 32'(rgb[1]),
                ((f / 2) % 2 == 0) ? 32'h0F0 : 32'hFFF);
            drive(10'd67, 10'd54, 1'b1);
            tick(6);
            chk($sformatf("blink f%0d grid", f), 32'(rgb[1]), 32'h700);
        end

        // Latency sweep: alive pixel surrounded by dead-cell addresses.
        mode = 1'b1; cur_x = 6'd40; cur_y = 6'd40;
        pulse_pixel(10'd60, 10'd54, 10'd68, 10'd54);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("lat%0d latency", d), 32'(lat[d]), 32'(3 + d));
            chk($sformatf("lat%0d rgb", d), 32'(rgbc[d]), 32'hFF0);
        end

        // Reset in the middle of a valid scan.
        drive(10'd51, 10'd51, 1'b1);
        tick(6);
        #2 rst = 1'b0;
        #1;
        chk("midreset disp_valid", 32'(dv[1]), 32'd0);
        chk("midreset rgb", 32'(rgb[1]), 32'h000);
        chk("midreset area", 32'(area[1]), 32'd0);
        @(posedge clk);
        #3;
        drive(10'd68, 10'd54, 1'b0);
        rst = 1'b1;
        tick(5);
        chk("postreset idle disp_valid", 32'(dv[1]), 32'd0);
        chk("postreset idle rgb", 32'(rgb[1]), 32'h000);
        pulse_pixel(10'd51, 10'd51, 10'd68, 10'd54);
        chk("postreset latency", 32'(lat[1]), 32'd4);
        chk("postreset rgb", 32'(rgbc[1]), 32'h333);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
